// File: rtl/serial_sched_defs.sv
// -----------------------------------------------------------------------------
// serial_sched_defs
//   Shared definitions for the serial transmitter scheduler and its
//   round-robin arbiter.
//   Contents:
//     sched_state_e : 2-bit scheduler state encoding
//     TIMER_W       : width of the acknowledge timeout counter (covers 1..255)
//     clog2()       : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package serial_sched_defs;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_e;

    localparam int TIMER_W = 8;

    // Smallest r with 2**r >= value. Returns 0 for value <= 1, so callers
    // that need a non-zero index width clamp the result to 1 themselves.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. The search starts at last_grant_i + 1
//   (mod N) and takes the first requester whose request bit is set, so the
//   most recently served requester has the lowest priority.
//   Ports:
//     req_i        in  N    request vector
//     last_grant_i in  IDW  index of the previously served requester (< N)
//     grant_o      out N    one-hot winner, all zero when req_i is zero
//     grant_idx_o  out IDW  index of the winner, zero when req_i is zero
// -----------------------------------------------------------------------------
module rr_arbiter
    import serial_sched_defs::*;
#(
    parameter  int N   = 4,
    localparam int IDW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] last_grant_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_idx_o
);

    // cand[k] is the requester examined at search offset k+1 from last grant;
    // hit[k] tells whether that requester is asking.
    logic [IDW-1:0] cand [N];
    logic [N-1:0]   hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        // One extra bit so last_grant + offset (at most 2N-1) cannot wrap.
        logic [IDW:0] sum;
        assign sum         = {1'b0, last_grant_i} + (IDW+1)'(gi + 1);
        assign cand[gi]    = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N))
                                                  : sum[IDW-1:0];
        assign hit[gi]     = req_i[cand[gi]];
    end

    // Walk offsets from farthest to nearest so the nearest hit is the one
    // left standing.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                grant_o          = '0;
                grant_o[cand[i]] = 1'b1;
                grant_idx_o      = cand[i];
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// -----------------------------------------------------------------------------
// serial_tx_scheduler
//   Shares one serial transmitter among N byte producers. In IDLE, with the
//   transmitter not busy, one requester is chosen round-robin, its word is
//   accepted with a one-cycle ready pulse and latched. The following cycle
//   strobes the transmitter, then the block waits for busy to rise
//   (acknowledge) and fall (frame end). If busy does not rise within
//   ACK_TIMEOUT cycles of the strobe, ack_err pulses and the word is dropped.
//   Ports:
//     clk        in   1        rising-edge clock
//     rst        in   1        synchronous active-high reset
//     req_valid  in   N        per-requester word available
//     req_data   in   N*WIDTH  requester i word at [i*WIDTH +: WIDTH]
//     req_ready  out  N        one-hot acceptance pulse
//     tx_ce      out  1        one-cycle start strobe to the transmitter
//     tx_data    out  WIDTH    word to transmit, stable for the whole frame
//     tx_busy    in   1        transmitter busy flag
//     grant_id   out  IDW      requester owning the current/last frame
//     active     out  1        high while a frame is owned
//     ack_err    out  1        one-cycle pulse on acknowledge timeout
// -----------------------------------------------------------------------------
module serial_tx_scheduler
    import serial_sched_defs::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int N           = 4,
    parameter  int ACK_TIMEOUT = 15,
    localparam int IDW         = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [N-1:0]         req_ready,
    output logic                 tx_ce,
    output logic [WIDTH-1:0]     tx_data,
    input  logic                 tx_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 active,
    output logic                 ack_err
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    sched_state_e       state_q,      state_d;
    logic [WIDTH-1:0]   tx_data_q,    tx_data_d;
    logic [IDW-1:0]     grant_id_q,   grant_id_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [TIMER_W-1:0] timer_q,      timer_d;

    // ------------------------------------------------------------------
    // Requester word slices
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] data_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // ------------------------------------------------------------------
    // Round-robin pick
    // ------------------------------------------------------------------
    logic [N-1:0]   arb_grant;
    logic [IDW-1:0] arb_idx;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx)
    );

    // A new frame may only start when the transmitter is idle; this also
    // covers a frame left running by a reset in the middle of it.
    logic can_grant;
    assign can_grant = (state_q == ST_IDLE) && !tx_busy && (|req_valid);

    // Timer reads 1 in the last WAIT_ACK cycle allowed; busy still wins there.
    logic timeout_hit;
    assign timeout_hit = (state_q == ST_WAIT_ACK) && !tx_busy &&
                         (timer_q == TIMER_W'(1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(N - 1);
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (can_grant) begin
                    state_d    = ST_ISSUE;
                    tx_data_d  = data_arr[arb_idx];
                    grant_id_d = arb_idx;
                end
            end

            ST_ISSUE: begin
                // Busy is deliberately not looked at here: even if it is
                // already high, acknowledge is taken in WAIT_ACK.
                timer_d = TIMER_W'(ACK_TIMEOUT);
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    // Word is dropped; the requester still counts as served.
                    state_d      = ST_IDLE;
                    last_grant_d = grant_id_q;
                    timer_d      = '0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_id_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        // Gated by rst so no word is taken in a cycle whose state update
        // is overridden by reset.
        if (can_grant && !rst) begin
            req_ready = arb_grant;
        end
        tx_ce    = (state_q == ST_ISSUE);
        active   = (state_q != ST_IDLE);
        ack_err  = timeout_hit;
        tx_data  = tx_data_q;
        grant_id = grant_id_q;
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_scheduler
//   Randomized bench with a timeline reference model. Each grant plans the
//   transmitter busy window for that frame; from the planned busy waveform
//   the model derives strobe cycle, ack_err cycle and the first cycle the
//   scheduler may grant again. Expectations go into queues, and a monitor
//   on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_serial_tx_scheduler;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int K     = 15;
    localparam int IDW   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N*WIDTH-1:0]   req_data  = '0;
    logic [N-1:0]         req_ready;
    logic                 tx_ce;
    logic [WIDTH-1:0]     tx_data;
    logic                 tx_busy = 1'b0;
    logic [IDW-1:0]       grant_id;
    logic                 active;
    logic                 ack_err;

    always #5 clk = ~clk;

    serial_tx_scheduler #(
        .WIDTH       (WIDTH),
        .N           (N),
        .ACK_TIMEOUT (K)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_ce     (tx_ce),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active),
        .ack_err   (ack_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Scoreboard types and queues
    // ------------------------------------------------------------------
    typedef struct { int cyc; int id; logic [WIDTH-1:0] data; } ce_exp_t;
    typedef struct { int cyc; int id; }                         err_exp_t;
    typedef struct { int cyc; logic [N-1:0] vec; logic act; }   cyc_exp_t;
    typedef struct { int s; int e; }                            win_t;

    ce_exp_t  ce_q[$];
    err_exp_t err_q[$];
    cyc_exp_t cyc_q[$];
    win_t     wins[$];

    int n_err = 0;
    int n_chk = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    bit               pend  [N];
    logic [WIDTH-1:0] pdata [N];
    int  last_srv   = N - 1;
    int  free_at    = 0;
    int  grant_t    = -100;
    int  grants     = 0;
    int  plan_mode  = 0;     // 0 random, 1 fixed d/len, 2 transmitter never acks
    int  d_fix      = 1;
    int  l_fix      = 4;
    bit  force_busy = 0;
    bit  rst_req    = 1;

    function automatic bit busy_at(input int c);
        foreach (wins[j]) begin
            if (c >= wins[j].s && c <= wins[j].e) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Next pending requester after the last one served, wrapping modulo N.
    function automatic int pick();
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (last_srv + off) % N;
            if (pend[c]) return c;
        end
        return 0;
    endfunction

    // Frame granted in cycle t: strobe at t+1, acknowledge window t+2..t+1+K.
    function automatic void plan_frame(input int t, input int w);
        int   d;
        int   len;
        int   a;
        int   e;
        bit   acked;
        win_t wn;
        err_exp_t er;
        if (plan_mode != 2) begin
            if (plan_mode == 1) begin
                d = d_fix; len = l_fix;
            end else begin
                d   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, K + 3))
                                                  : int'($urandom_range(0, 2));
                len = int'($urandom_range(2, 6));
            end
            wn.s = t + 1 + d;
            wn.e = t + d + len;
            wins.push_back(wn);
        end
        acked = 0;
        a     = 0;
        for (int c = t + 2; c <= t + 1 + K; c++) begin
            if (!acked && busy_at(c)) begin
                acked = 1;
                a     = c;
            end
        end
        if (acked) begin
            e = a + 1;
            while (busy_at(e)) e++;
            free_at = e + 1;
        end else begin
            er.cyc = t + 1 + K;
            er.id  = w;
            err_q.push_back(er);
            free_at = t + 2 + K;
        end
    endfunction

    // ------------------------------------------------------------------
    // One clock of stimulus plus model update
    // ------------------------------------------------------------------
    task automatic run_cycle(input int new_pct, input bit seq_data,
                             input logic [N-1:0] mask);
        cyc_exp_t ex;
        ce_exp_t  ce;
        ce_exp_t  ce_keep[$];
        err_exp_t er_keep[$];
        bit       any;
        int       w;
        @(posedge clk);
        #1;
        rst = rst_req;
        while (wins.size() > 0 && wins[0].e < cyc - 1) void'(wins.pop_front());
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && mask[i] && int'($urandom_range(0, 99)) < new_pct) begin
                pend[i]  = 1;
                pdata[i] = seq_data ? WIDTH'(8'h10 + i) : WIDTH'($urandom);
            end
        end
        any = 0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]                = pend[i];
            req_data[i*WIDTH +: WIDTH]  = pdata[i];
            any                         = any | pend[i];
        end
        tx_busy = force_busy || busy_at(cyc);

        ex.cyc = cyc;
        ex.vec = '0;
        ex.act = (cyc > grant_t) && (cyc < free_at);
        if (rst) begin
            free_at  = cyc + 1;
            last_srv = N - 1;
            foreach (ce_q[j])  if (ce_q[j].cyc <= cyc)  ce_keep.push_back(ce_q[j]);
            foreach (err_q[j]) if (err_q[j].cyc <= cyc) er_keep.push_back(err_q[j]);
            ce_q  = ce_keep;
            err_q = er_keep;
        end else if (cyc >= free_at && !tx_busy && any) begin
            w         = pick();
            ex.vec[w] = 1'b1;
            ce.cyc    = cyc + 1;
            ce.id     = w;
            ce.data   = pdata[w];
            ce_q.push_back(ce);
            plan_frame(cyc, w);
            pend[w]  = 0;
            last_srv = w;
            grant_t  = cyc;
            grants++;
        end
        cyc_q.push_back(ex);
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
        check({tag, "_tx_ce"},     32'(tx_ce),     32'(0));
        check({tag, "_tx_data"},   32'(tx_data),   32'(0));
        check({tag, "_grant_id"},  32'(grant_id),  32'(0));
        check({tag, "_active"},    32'(active),    32'(0));
        check({tag, "_ack_err"},   32'(ack_err),   32'(0));
    endtask

    task automatic drain(input string tag);
        int  n;
        bit  idle;
        n = 0;
        idle = 0;
        while (n < 400 && !idle) begin
            run_cycle(0, 0, '0);
            n++;
            idle = (ce_q.size() == 0) && (err_q.size() == 0) &&
                   (cyc >= free_at) && !busy_at(cyc);
            for (int i = 0; i < N; i++) if (pend[i]) idle = 0;
        end
        check({tag, "_drain_bound"}, 32'(idle), 32'(1));
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        cyc_exp_t ex;
        ce_exp_t  ce;
        err_exp_t er;
        bit       exp_ce;
        bit       exp_err;
        if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
            ex = cyc_q.pop_front();
            check("req_ready", 32'(req_ready), 32'(ex.vec));
            check("active",    32'(active),    32'(ex.act));

            exp_ce = (ce_q.size() > 0) && (ce_q[0].cyc == cyc);
            check("tx_ce", 32'(tx_ce), 32'(exp_ce));
            if (exp_ce) begin
                ce = ce_q.pop_front();
                check("tx_data",  32'(tx_data),  32'(ce.data));
                check("grant_id", 32'(grant_id), 32'(ce.id));
                $display("strobe cyc=%0d id=%0d data=0x%02h", cyc, ce.id, ce.data);
            end

            exp_err = (err_q.size() > 0) && (err_q[0].cyc == cyc);
            check("ack_err", 32'(ack_err), 32'(exp_err));
            if (exp_err) begin
                er = err_q.pop_front();
                check("err_grant_id", 32'(grant_id), 32'(er.id));
                $display("ack_err cyc=%0d id=%0d", cyc, er.id);
            end
        end
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int g0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 0;
            pdata[i] = '0;
        end

        // Reset values
        rst_req = 1;
        repeat (3) run_cycle(0, 0, '0);
        rst_req = 0;
        run_cycle(0, 0, '0);
        check_zero("reset");

        // Single request from requester 0 with 0xA5
        plan_mode = 1; d_fix = 1; l_fix = 4;
        pend[0] = 1; pdata[0] = 8'hA5;
        drain("single");

        // Random arrivals and random acknowledge behaviour
        plan_mode = 0;
        repeat (600) run_cycle(30, 0, '1);
        drain("random");

        // All requesters continuously valid, 0x10..0x13, long frames
        plan_mode = 1; d_fix = 1; l_fix = 10;
        repeat (80) run_cycle(100, 1, '1);
        drain("all_valid");

        // Requester 2 only, back-to-back
        plan_mode = 1; d_fix = 1; l_fix = 3;
        repeat (40) run_cycle(100, 0, 4'b0100);
        drain("req2_only");

        // Transmitter never acknowledges
        plan_mode = 2;
        repeat (120) run_cycle(40, 0, '1);
        drain("no_ack");

        // Busy held externally while requester 0 waits; busy already high at strobe
        plan_mode = 1; d_fix = 0; l_fix = 3;
        force_busy = 1;
        pend[0] = 1; pdata[0] = 8'h77;
        repeat (10) run_cycle(0, 0, '0);
        force_busy = 0;
        drain("ext_busy");

        // Reset in the middle of a long frame
        plan_mode = 1; d_fix = 1; l_fix = 25;
        pend[1] = 1; pdata[1] = 8'h3C;
        g0 = grants;
        n  = 0;
        while (grants == g0 && n < 50) begin
            run_cycle(0, 0, '0);
            n++;
        end
        check("rst_mid_grant_bound", 32'(grants - g0), 32'(1));
        repeat (6) run_cycle(0, 0, '0);
        pend[2] = 1; pdata[2] = 8'hC3;
        rst_req = 1;
        run_cycle(0, 0, '0);
        rst_req = 0;
        run_cycle(0, 0, '0);
        check_zero("rst_mid");
        drain("rst_mid");

        repeat (3) run_cycle(0, 0, '0);
        check("ce_queue_left",  32'(ce_q.size()),  32'(0));
        check("err_queue_left", 32'(err_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
